// File: rtl/pipe_reg.sv
// Elastic valid/ready pipeline register: NUM_STAGES data registers, each with its
// own valid bit. Supports backpressure, bubble collapsing and a synchronous flush.
module pipe_reg #(
    parameter int                    ELEM_WIDTH  = 32,
    parameter int                    NUM_STAGES  = 2,
    parameter logic [ELEM_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                              clk_i,
    input  logic                              arst_i,
    input  logic                              flush_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [ELEM_WIDTH-1:0]             in_data_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [ELEM_WIDTH-1:0]             out_data_o,
    output logic [$clog2(NUM_STAGES+1)-1:0]   occupancy_o
);

    localparam int OCC_W = $clog2(NUM_STAGES + 1);

    if (NUM_STAGES < 1) begin : g_bad_stages
        $error("pipe_reg: NUM_STAGES must be >= 1");
    end

    logic [NUM_STAGES-1:0]                 vld_pipe;
    logic [NUM_STAGES-1:0][ELEM_WIDTH-1:0] data_q;
    logic [NUM_STAGES-1:0]                 adv;
    logic [OCC_W-1:0]                      occ_cnt;

    // adv[k]: the slot downstream of stage k can take a word this cycle. An empty
    // stage always reports ready, which is what squeezes bubbles out under stall.
    always_comb begin
        adv = '0;
        adv[NUM_STAGES-1] = out_ready_i;
        for (int k = NUM_STAGES - 2; k >= 0; k--)
            adv[k] = !vld_pipe[k+1] || adv[k+1];
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            vld_pipe <= '0;
            data_q   <= {NUM_STAGES{RESET_VALUE}};
        end else if (flush_i) begin
            vld_pipe <= '0;
        end else begin
            if (adv[0]) begin
                vld_pipe[0] <= in_valid_i;
                data_q[0]   <= in_data_i;
            end
            // Data only follows a valid word, so bubbles never overwrite payload.
            for (int k = 1; k < NUM_STAGES; k++) begin
                if (adv[k-1]) begin
                    vld_pipe[k] <= vld_pipe[k-1];
                    if (vld_pipe[k-1])
                        data_q[k] <= data_q[k-1];
                end
            end
        end
    end

    always_comb begin
        occ_cnt = '0;
        for (int k = 0; k < NUM_STAGES; k++)
            occ_cnt = occ_cnt + OCC_W'(vld_pipe[k]);
    end

    // Combinational ready path from out_ready_i is deliberate (no skid buffer).
    assign in_ready_o  = adv[0] && !flush_i && !arst_i;
    assign out_valid_o = vld_pipe[NUM_STAGES-1];
    assign out_data_o  = data_q[NUM_STAGES-1];
    assign occupancy_o = occ_cnt;

endmodule

// File: tb/tb_pipe_reg.sv
// Bench for pipe_reg: five instances (NUM_STAGES 1..5), directed steps plus a
// randomized phase, checked against a queue scoreboard fed by accepted words.
module tb_pipe_reg;

    localparam int NI = 5;

    logic                   clk  = 1'b0;
    logic                   arst = 1'b0;
    logic [NI-1:0]          in_valid  = '0;
    logic [NI-1:0]          out_ready = '0;
    logic [NI-1:0]          flush     = '0;
    logic [NI-1:0][31:0]    in_data   = '0;
    logic [NI-1:0]          in_ready;
    logic [NI-1:0]          out_valid;
    logic [NI-1:0][31:0]    out_data;
    logic [NI-1:0][2:0]     occ;

    int          checks   = 0;
    int          failures = 0;
    int          d        = 0;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int N = g + 1;
        logic [$clog2(N+1)-1:0] occ_w;
        pipe_reg #(.ELEM_WIDTH(32), .NUM_STAGES(N), .RESET_VALUE(32'h0)) u_dut (
            .clk_i      (clk),
            .arst_i     (arst),
            .flush_i    (flush[g]),
            .in_valid_i (in_valid[g]),
            .in_ready_o (in_ready[g]),
            .in_data_i  (in_data[g]),
            .out_valid_o(out_valid[g]),
            .out_ready_i(out_ready[g]),
            .out_data_o (out_data[g]),
            .occupancy_o(occ_w)
        );
        assign occ[g] = 3'(occ_w);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive instance d (others idle) at the falling edge, then let outputs settle.
    task automatic drive(input logic v, input logic [31:0] dat, input logic r, input logic f);
        in_valid = '0; out_ready = '0; flush = '0;
        in_valid[d] = v; in_data[d] = dat; out_ready[d] = r; flush[d] = f;
        #1;
    endtask

    // Score the handshakes that the coming posedge will complete, then advance.
    task automatic cyc();
        chk("occupancy", 32'(occ[d]), 32'(q.size()));
        if (flush[d]) q.delete();
        else begin
            if (out_valid[d] && out_ready[d]) begin
                chk("pop_has_entry", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) chk("out_data", out_data[d], q.pop_front());
            end
            if (in_valid[d] && in_ready[d]) q.push_back(in_data[d]);
        end
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin drive(1'b0, 32'h0, 1'b1, 1'b0); cyc(); end
    endtask

    // Push one word into an empty pipe of depth n and check when it surfaces.
    task automatic lat_probe(input int n, input logic [31:0] w);
        drive(1'b1, w, 1'b1, 1'b0);
        chk("lat_in_ready", 32'(in_ready[d]), 32'd1);
        cyc();
        for (int i = 1; i < n; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            chk("lat_early_valid", 32'(out_valid[d]), 32'd0);
            cyc();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("lat_valid", 32'(out_valid[d]), 32'd1);
        chk("lat_data", out_data[d], w);
        cyc();
    endtask

    task automatic rst_checks(input int i);
        chk("rst_occ",       32'(occ[i]),       32'd0);
        chk("rst_out_valid", 32'(out_valid[i]), 32'd0);
        chk("rst_out_data",  out_data[i],       32'd0);
        chk("rst_in_ready",  32'(in_ready[i]),  32'd0);
    endtask

    initial begin
        int mx, n;
        logic pv, pr, pf;

        // Reset with both handshakes asserted: in_ready must still stay low.
        #1 arst = 1'b1; in_valid = '1; out_ready = '1;
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < NI; i++) rst_checks(i);
        arst = 1'b0; in_valid = '0; out_ready = '0;
        @(negedge clk);

        // Streaming, N=3: first output after e0+2, then one per cycle.
        d = 2; mx = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) drive(1'b1, 32'(i + 1), 1'b1, 1'b0);
            else       drive(1'b0, 32'h0,      1'b1, 1'b0);
            chk("stream_in_ready",  32'(in_ready[d]),  32'd1);
            chk("stream_out_valid", 32'(out_valid[d]), 32'(i >= 3 && i <= 6));
            if (int'(occ[d]) > mx) mx = int'(occ[d]);
            cyc();
        end
        chk("stream_peak_occ", 32'(mx), 32'd3);

        // Backpressure, N=3: three accepted, fourth stalls, contents held.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h10 + 32'(i < 3 ? i : 3), 1'b0, 1'b0);
            chk("bp_in_ready", 32'(in_ready[d]), 32'(i < 3));
            if (i >= 3) begin
                chk("bp_hold_data",  out_data[d],       32'h10);
                chk("bp_hold_occ",   32'(occ[d]),       32'd3);
                chk("bp_hold_valid", 32'(out_valid[d]), 32'd1);
            end
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h13 + 32'(i), 1'b1, 1'b0);
            chk("bp_swap_in_ready", 32'(in_ready[d]), 32'd1);
            chk("bp_swap_occ",      32'(occ[d]),      32'd3);
            cyc();
        end
        drain(4);

        // Asynchronous reset with two words held and a push pending.
        drive(1'b1, 32'h21, 1'b0, 1'b0); cyc();
        drive(1'b1, 32'h22, 1'b0, 1'b0); cyc();
        drive(1'b0, 32'h0,  1'b0, 1'b0); cyc();
        drive(1'b1, 32'h23, 1'b1, 1'b0);
        chk("pre_rst_valid", 32'(out_valid[d]), 32'd1);
        chk("pre_rst_occ",   32'(occ[d]),       32'd2);
        arst = 1'b1; #1;
        rst_checks(d);
        q.delete();
        @(negedge clk);
        arst = 1'b0;
        lat_probe(3, 32'hA5A5_A5A5);

        // Flush of a full pipe overrides push and pop.
        for (int i = 0; i < 3; i++) begin drive(1'b1, 32'h31 + 32'(i), 1'b0, 1'b0); cyc(); end
        drive(1'b1, 32'h99, 1'b1, 1'b1);
        chk("flush_pre_occ",   32'(occ[d]),       32'd3);
        chk("flush_in_ready",  32'(in_ready[d]),  32'd0);
        chk("flush_pre_valid", 32'(out_valid[d]), 32'd1);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("flush_occ",       32'(occ[d]),       32'd0);
        chk("flush_out_valid", 32'(out_valid[d]), 32'd0);
        cyc();
        lat_probe(3, 32'h55);

        // Bubble collapse, N=4: 0xBB closes up behind 0xAA while stalled.
        d = 3;
        drive(1'b1, 32'hAA, 1'b0, 1'b0); cyc();
        drive(1'b0, 32'h0,  1'b0, 1'b0); cyc();
        drive(1'b0, 32'h0,  1'b0, 1'b0); cyc();
        drive(1'b1, 32'hBB, 1'b0, 1'b0); cyc();
        drive(1'b0, 32'h0,  1'b0, 1'b0); cyc();
        drive(1'b0, 32'h0,  1'b0, 1'b0); cyc();
        drive(1'b0, 32'h0,  1'b1, 1'b0);
        chk("bub_occ",  32'(occ[d]), 32'd2);
        chk("bub_head", out_data[d], 32'hAA);
        cyc();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("bub_adj_valid", 32'(out_valid[d]), 32'd1);
        chk("bub_adj_data",  out_data[d],       32'hBB);
        cyc();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("bub_empty", 32'(out_valid[d]), 32'd0);
        cyc();

        // Random traffic on N = 1, 2, 5.
        for (int k = 0; k < 3; k++) begin
            d = (k == 0) ? 0 : (k == 1) ? 1 : 4;
            n = d + 1;
            q.delete(); pv = 1'b0; pr = 1'b0; pf = 1'b0;
            for (int c = 0; c < 340; c++) begin
                drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 31) == 0);
                if (out_valid[d]) chk("rnd_valid_has_entry", 32'(q.size() != 0), 32'd1);
                if (pv && !pr && !pf) chk("rnd_valid_stable", 32'(out_valid[d]), 32'd1);
                if (!flush[d] && q.size() == 0 && (n > 1 || out_ready[d]))
                    chk("rnd_empty_ready", 32'(in_ready[d]), 32'd1);
                if (q.size() == n && !out_ready[d])
                    chk("rnd_full_stall", 32'(in_ready[d]), 32'd0);
                if (flush[d]) chk("rnd_flush_ready", 32'(in_ready[d]), 32'd0);
                pv = out_valid[d]; pr = out_ready[d]; pf = flush[d];
                cyc();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_reg.md
Name: pipe_reg

Overview:
- Parametrised elastic pipeline register; successor to the single enable-gated register.
- Chains NUM_STAGES data registers, each with its own valid bit, using a valid/ready handshake on both sides.
- Supports backpressure, bubble collapsing and a synchronous flush.
- Used between processor pipeline stages and on any path that needs registered latency with flow control.

Parameters:
- ELEM_WIDTH, 32, width of the data word.
- NUM_STAGES, 2, number of register stages (must be >= 1; elaboration-time assertion otherwise).
- RESET_VALUE, '0, value loaded into every data stage on reset.

Ports:
- clk_i  input  1  clock; all state updates on posedge.
- arst_i  input  1  asynchronous reset, active-high.
- flush_i  input  1  synchronous flush; invalidates all stages at the next posedge.
- in_valid_i  input  1  upstream has a word on in_data_i.
- in_ready_o  output  1  block accepts a word this cycle.
- in_data_i  input  ELEM_WIDTH  upstream data.
- out_valid_o  output  1  stage NUM_STAGES-1 holds a valid word.
- out_ready_i  input  1  downstream accepts a word this cycle.
- out_data_o  output  ELEM_WIDTH  data of stage NUM_STAGES-1.
- occupancy_o  output  $clog2(NUM_STAGES+1)  number of valid stages.

Behaviour:
- Reset (arst_i=1, asynchronous):
  - all valid bits 0; all data stages = RESET_VALUE.
  - out_valid_o=0, out_data_o=RESET_VALUE, occupancy_o=0.
  - in_ready_o=0 while arst_i=1.
- Stage indexing: stage 0 is fed from the input; stage NUM_STAGES-1 drives the outputs.
- Advance rules (combinational):
  - adv[N-1] = out_ready_i.
  - adv[k] = !valid[k+1] || adv[k+1].
- Load conditions:
  - Stage k (k>0) loads stage k-1 when adv[k-1]. Its valid becomes valid[k-1]; data copies only when valid[k-1]=1.
  - Stage 0 loads in_data_i when adv[0]. Its valid becomes in_valid_i.
- Stage hold: when a stage does not advance, its data and valid are held.
- Bubble collapsing: an empty stage always advances, so bubbles are squeezed out even while out_ready_i=0.
- in_ready_o = adv[0] && !flush_i && !arst_i. This is a combinational path from out_ready_i and is intentional.
- Transfer occurs on a side only at a posedge where that side's valid && ready are both 1.
- Latency: a word accepted at edge e0 into an empty pipe gives out_valid_o=1 after edge e0+(NUM_STAGES-1).
  - NUM_STAGES=1: visible right after the accepting edge.
- Throughput: 1 word/cycle sustained when out_ready_i=1.
- Full pipe: all valid=1 and out_ready_i=0 gives in_ready_o=0. Contents, out_data_o and occupancy_o are held stable.
- Full pipe with out_ready_i=1: a simultaneous pop and push happen at the same edge; occupancy stays NUM_STAGES.
- Flush (flush_i=1 at a posedge):
  - all valid bits cleared; data registers keep their values.
  - in_ready_o=0, so no word is accepted; an output word presented that cycle is not counted as transferred.
  - occupancy_o=0 after the edge.
  - Flush overrides any simultaneous push or advance.
- Reset mid-operation: the pipe empties immediately (asynchronously), regardless of handshake state. Normal operation resumes at the first posedge after deassertion.
- occupancy_o = popcount(valid) from registered state only; it never depends on the current-cycle handshake.
- Data integrity: words leave in acceptance order. None duplicated, none dropped, except by flush or reset.
- out_valid_o must not drop while out_ready_i=0, except on flush or reset.

Test Plan:
- Reset: arst_i=1 mid-run with 2 words held (N=3) -> out_valid_o=0, out_data_o=0, occupancy_o=0, in_ready_o=0 immediately; after release, push 0xA5A5A5A5 -> appears at output 2 edges after acceptance.
- Latency/streaming: N=3, out_ready_i=1, push 0x1,0x2,0x3,0x4 on consecutive edges -> out_valid_o first high after edge e0+2; outputs 0x1..0x4 on consecutive cycles; occupancy_o peaks at 3.
- Backpressure: N=3, out_ready_i=0, push 0x10,0x11,0x12,0x13 -> first three accepted; in_ready_o=0 on the fourth; out_data_o=0x10 held stable; occupancy_o=3. Then out_ready_i=1 with in_valid_i=1 -> one pop and one push per edge; occupancy_o stays 3.
- Bubble collapse: N=4, out_ready_i=0, push 0xAA, idle 2 cycles, push 0xBB -> 0xAA reaches stage 3; 0xBB reaches stage 2 (adjacent); occupancy_o=2; drain yields 0xAA then 0xBB.
- Flush: N=3 holding 3 words, flush_i=1 for one edge with in_valid_i=1 and out_ready_i=1 -> next cycle occupancy_o=0, out_valid_o=0; flushed-cycle input not accepted; subsequent push 0x55 emerges after 2 edges.
- Random (1000 cycles, N in {1,2,5}): random in_valid_i, out_ready_i and rare flush_i vs a queue reference model -> zero order/data mismatches; occupancy_o always equals the model's queue size.
